capture_input_conditioner: RTL and testbench

Front-end conditioning stage that turns three raw, asynchronous control inputs into clean single-cycle rising-edge pulses. The inputs are start, capture and reset-capture. It feeds the capture FSM's `start_in_rising_i`, `capture_in_rising_i` and `rst_capture_in_rising_i` ports directly. Each channel has a multi-flop synchronizer, a debounce state machine and a rising-edge pulse generator. A shared saturating counter reports rejected glitches.

---
 rtl/capture_input_conditioner.sv | 175 +++++++++++++++++
 tb/tb_capture_input_conditioner.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_input_conditioner.sv
// -----------------------------------------------------------------------------
// capture_input_conditioner
//
// Turns three raw, asynchronous control inputs (start, capture, reset-capture)
// into clean single-cycle rising-edge pulses for the capture FSM. Each channel
// runs a multi-flop synchronizer, a debounce state machine and a registered
// rising-edge pulse generator. A shared saturating counter tallies rejected
// glitches.
//
// Parameters:
//   SYNC_STAGES      synchronizer flops per channel (>= 2)
//   DEBOUNCE_CYCLES  consecutive differing synchronized samples needed to
//                    accept a new level (1..65535)
//
// Ports:
//   clk_i                    single clock for the whole block
//   rst_an_i                 asynchronous active-low reset
//   start_i                  raw start (asynchronous)
//   capture_i                raw capture (asynchronous)
//   rst_capture_i            raw reset-capture (asynchronous)
//   clear_glitch_i           synchronous clear of glitch_cnt_o
//   start_in_rising_o        one-cycle pulse on accepted 0->1 of start
//   capture_in_rising_o      one-cycle pulse on accepted 0->1 of capture
//   rst_capture_in_rising_o  one-cycle pulse on accepted 0->1 of reset-capture
//   level_o                  debounced levels {rst_capture, capture, start}
//   glitch_cnt_o             saturating count of rejected transitions
// -----------------------------------------------------------------------------
module capture_input_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic        clk_i,
   input  logic        rst_an_i,
   input  logic        start_i,
   input  logic        capture_i,
   input  logic        rst_capture_i,
   input  logic        clear_glitch_i,
   output logic        start_in_rising_o,
   output logic        capture_in_rising_o,
   output logic        rst_capture_in_rising_o,
   output logic [2:0]  level_o,
   output logic [15:0] glitch_cnt_o
);

   localparam int NUM_CH = 3;
   localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'b00,
      ARM_HIGH    = 2'b01,
      STABLE_HIGH = 2'b10,
      ARM_LOW     = 2'b11
   } deb_state_t;

   logic [NUM_CH-1:0] raw_s;
   logic [NUM_CH-1:0] glitch_s;
   logic [NUM_CH-1:0] pulse_s;
   logic [NUM_CH-1:0] level_s;

   assign raw_s = {rst_capture_i, capture_i, start_i};

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_r;
      logic                   sync_s;
      deb_state_t             state_r;
      deb_state_t             state_nxt_s;
      logic [CNT_W-1:0]       cnt_r;
      logic [CNT_W-1:0]       cnt_nxt_s;
      logic                   stable_r;
      logic                   stable_nxt_s;
      logic                   pulse_r;
      logic                   pulse_nxt_s;
      logic                   arm_s;
      logic                   chan_glitch_s;

      // Synchronizer shift chain; bit 0 samples the raw asynchronous input.
      always_ff @(posedge clk_i or negedge rst_an_i) begin
         if (!rst_an_i) begin
            sync_r <= {SYNC_STAGES{1'b0}};
         end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw_s[ch]};
         end
      end

      assign sync_s = sync_r[SYNC_STAGES-1];

      // Debounce state, counter, accepted level and rising pulse registers.
      always_ff @(posedge clk_i or negedge rst_an_i) begin
         if (!rst_an_i) begin
            state_r  <= STABLE_LOW;
            cnt_r    <= CNT_ZERO;
            stable_r <= 1'b0;
            pulse_r  <= 1'b0;
         end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            stable_r <= stable_nxt_s;
            pulse_r  <= pulse_nxt_s;
         end
      end

      // Debounce next-state: accept after DEBOUNCE_CYCLES differing samples,
      // reject (and flag a glitch) if the input returns early.
      always_comb begin
         state_nxt_s   = state_r;
         cnt_nxt_s     = cnt_r;
         stable_nxt_s  = stable_r;
         pulse_nxt_s   = 1'b0;
         chan_glitch_s = 1'b0;
         arm_s         = 1'b0;

         case (state_r)
            ARM_HIGH, ARM_LOW: arm_s = 1'b1;
            default:           arm_s = 1'b0;
         endcase

         if (sync_s == stable_r) begin
            cnt_nxt_s     = CNT_ZERO;
            chan_glitch_s = arm_s;
            state_nxt_s   = stable_r ? STABLE_HIGH : STABLE_LOW;
         end else if (cnt_r == CNT_MAX) begin
            // The pulse register loads together with stable, so the pulse is
            // high in exactly the first cycle stable reads 1.
            cnt_nxt_s    = CNT_ZERO;
            stable_nxt_s = sync_s;
            pulse_nxt_s  = sync_s;
            state_nxt_s  = sync_s ? STABLE_HIGH : STABLE_LOW;
         end else begin
            cnt_nxt_s   = cnt_r + CNT_ONE;
            state_nxt_s = sync_s ? ARM_HIGH : ARM_LOW;
         end
      end

      assign glitch_s[ch] = chan_glitch_s;
      assign pulse_s[ch]  = pulse_r;
      assign level_s[ch]  = stable_r;
   end

   logic [1:0]  glitch_sum_s;
   logic [16:0] glitch_add_s;
   logic [15:0] glitch_nxt_s;
   logic [15:0] glitch_cnt_r;

   // Glitch counter next value: add 0..3 per cycle, saturate, clear wins.
   always_comb begin
      glitch_sum_s = {1'b0, glitch_s[0]} + {1'b0, glitch_s[1]} + {1'b0, glitch_s[2]};
      glitch_add_s = {1'b0, glitch_cnt_r} + {15'd0, glitch_sum_s};
      if (clear_glitch_i) begin
         glitch_nxt_s = 16'h0000;
      end else if (glitch_add_s[16]) begin
         glitch_nxt_s = 16'hFFFF;
      end else begin
         glitch_nxt_s = glitch_add_s[15:0];
      end
   end

   // Glitch counter register.
   always_ff @(posedge clk_i or negedge rst_an_i) begin
      if (!rst_an_i) begin
         glitch_cnt_r <= 16'h0000;
      end else begin
         glitch_cnt_r <= glitch_nxt_s;
      end
   end

   assign start_in_rising_o       = pulse_s[0];
   assign capture_in_rising_o     = pulse_s[1];
   assign rst_capture_in_rising_o = pulse_s[2];
   assign level_o                 = level_s;
   assign glitch_cnt_o            = glitch_cnt_r;

endmodule

// File: tb/tb_capture_input_conditioner.sv
// -----------------------------------------------------------------------------
// Self-checking bench for capture_input_conditioner (default parameters).
// A behavioural model tracks, per channel, the raw sample history delayed by
// the synchronizer depth and the length of the current run of samples that
// differ from the accepted level; runs reaching DEBOUNCE_CYCLES are accepted,
// shorter runs that end are glitches.
// -----------------------------------------------------------------------------
module tb_capture_input_conditioner;

   localparam int SS = 2;
   localparam int DC = 4;

   logic        clk = 1'b0;
   logic        rst_an_i;
   logic        start_i, capture_i, rst_capture_i, clear_glitch_i;
   logic        start_in_rising_o, capture_in_rising_o, rst_capture_in_rising_o;
   logic [2:0]  level_o;
   logic [15:0] glitch_cnt_o;
   logic [2:0]  dut_pulse;

   int checks = 0;
   int errors = 0;

   // model state
   logic [2:0]  m_raw_q[$];
   bit   [2:0]  m_stable;
   bit   [2:0]  m_pulse;
   int          m_run[3];
   logic [15:0] m_gcnt;

   always #5 clk = ~clk;

   assign dut_pulse = {rst_capture_in_rising_o, capture_in_rising_o, start_in_rising_o};

   capture_input_conditioner #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) dut (
      .clk_i                   (clk),
      .rst_an_i                (rst_an_i),
      .start_i                 (start_i),
      .capture_i               (capture_i),
      .rst_capture_i           (rst_capture_i),
      .clear_glitch_i          (clear_glitch_i),
      .start_in_rising_o       (start_in_rising_o),
      .capture_in_rising_o     (capture_in_rising_o),
      .rst_capture_in_rising_o (rst_capture_in_rising_o),
      .level_o                 (level_o),
      .glitch_cnt_o            (glitch_cnt_o)
   );

   task automatic model_reset();
      m_raw_q.delete();
      for (int i = 0; i < SS; i++) m_raw_q.push_back(3'b000);
      m_stable = 3'b000;
      m_pulse  = 3'b000;
      for (int c = 0; c < 3; c++) m_run[c] = 0;
      m_gcnt = 16'h0000;
   endtask

   task automatic model_edge(input logic [2:0] raw, input logic clr);
      logic [2:0] s;
      int nglitch;
      int sum;
      s = m_raw_q.pop_front();
      m_raw_q.push_back(raw);
      nglitch = 0;
      for (int c = 0; c < 3; c++) begin
         m_pulse[c] = 1'b0;
         if (s[c] != m_stable[c]) begin
            m_run[c]++;
            if (m_run[c] == DC) begin
               m_stable[c] = s[c];
               m_pulse[c]  = s[c];
               m_run[c]    = 0;
            end
         end else begin
            if (m_run[c] > 0) nglitch++;
            m_run[c] = 0;
         end
      end
      sum = int'(m_gcnt) + nglitch;
      if (clr) m_gcnt = 16'h0000;
      else if (sum > 65535) m_gcnt = 16'hFFFF;
      else m_gcnt = sum[15:0];
   endtask

   // Drive one cycle of inputs, advance the model at the edge, return at negedge.
   task automatic cycle(input logic [2:0] raw, input logic clr);
      start_i        = raw[0];
      capture_i      = raw[1];
      rst_capture_i  = raw[2];
      clear_glitch_i = clr;
      @(posedge clk);
      model_edge(raw, clr);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_an_i = 1'b0;
      start_i = 1'b0; capture_i = 1'b0; rst_capture_i = 1'b0; clear_glitch_i = 1'b0;
      model_reset();
      #1;
      if ({dut_pulse, level_o, glitch_cnt_o} !== 22'd0) begin
         errors++;
         $display("FAIL reset_state: got p=%b l=%b g=%h, expected all zero", dut_pulse, level_o, glitch_cnt_o);
      end
      checks++;
      @(negedge clk);
      rst_an_i = 1'b1;
   endtask

   task automatic test_clean_rise();
      int npulse = 0;
      int first = -1;
      for (int i = 0; i < 20; i++) begin
         cycle(3'b001, 1'b0);
         if (start_in_rising_o === 1'b1) begin
            npulse++;
            if (first < 0) first = i;
         end
         if ({dut_pulse, level_o, glitch_cnt_o} !== {m_pulse, m_stable, m_gcnt}) begin
            errors++;
            $display("FAIL clean_rise_model cyc %0d: got p=%b l=%b g=%h, expected p=%b l=%b g=%h",
                     i, dut_pulse, level_o, glitch_cnt_o, m_pulse, m_stable, m_gcnt);
         end
         checks++;
      end
      if (npulse != 1 || first != SS + DC - 1) begin
         errors++;
         $display("FAIL clean_rise_latency: got %0d pulses first after edge %0d, expected 1 after edge %0d",
                  npulse, first, SS + DC - 1);
      end
      checks++;
      if (level_o !== 3'b001 || glitch_cnt_o !== 16'h0000) begin
         errors++;
         $display("FAIL clean_rise_level: got l=%b g=%h, expected l=001 g=0000", level_o, glitch_cnt_o);
      end
      checks++;
      for (int i = 0; i < 10; i++) begin
         cycle(3'b000, 1'b0);
         if ({dut_pulse, level_o, glitch_cnt_o} !== {m_pulse, m_stable, m_gcnt}) begin
            errors++;
            $display("FAIL clean_fall_model cyc %0d: got p=%b l=%b g=%h, expected p=%b l=%b g=%h",
                     i, dut_pulse, level_o, glitch_cnt_o, m_pulse, m_stable, m_gcnt);
         end
         checks++;
      end
   endtask

   task automatic test_glitch();
      int npulse = 0;
      int nlevel = 0;
      for (int i = 0; i < 13; i++) begin
         cycle((i < 3) ? 3'b010 : 3'b000, 1'b0);
         if (capture_in_rising_o === 1'b1) npulse++;
         if (level_o[1] !== 1'b0) nlevel++;
         if ({dut_pulse, level_o, glitch_cnt_o} !== {m_pulse, m_stable, m_gcnt}) begin
            errors++;
            $display("FAIL glitch_model cyc %0d: got p=%b l=%b g=%h, expected p=%b l=%b g=%h",
                     i, dut_pulse, level_o, glitch_cnt_o, m_pulse, m_stable, m_gcnt);
         end
         checks++;
      end
      if (npulse != 0 || nlevel != 0 || glitch_cnt_o !== 16'd1) begin
         errors++;
         $display("FAIL glitch_reject: got pulses=%0d level_high_cycles=%0d g=%h, expected 0 0 0001",
                  npulse, nlevel, glitch_cnt_o);
      end
      checks++;
   endtask

   task automatic test_fall_rerise();
      int npulse = 0;
      for (int i = 0; i < 40; i++) begin
         cycle(((i / 10) % 2 == 0) ? 3'b010 : 3'b000, 1'b0);
         if (capture_in_rising_o === 1'b1) npulse++;
         if ({dut_pulse, level_o, glitch_cnt_o} !== {m_pulse, m_stable, m_gcnt}) begin
            errors++;
            $display("FAIL fall_rerise_model cyc %0d: got p=%b l=%b g=%h, expected p=%b l=%b g=%h",
                     i, dut_pulse, level_o, glitch_cnt_o, m_pulse, m_stable, m_gcnt);
         end
         checks++;
      end
      if (npulse != 2) begin
         errors++;
         $display("FAIL fall_rerise_count: got %0d capture pulses, expected 2", npulse);
      end
      checks++;
   endtask

   task automatic test_simultaneous();
      int nall = 0;
      int npart = 0;
      for (int i = 0; i < 33; i++) begin
         if (i < 10) cycle(3'b111, 1'b0);
         else if (i < 20) cycle(3'b000, 1'b0);
         else if (i < 23) cycle(3'b111, 1'b0);
         else cycle(3'b000, 1'b0);
         if (dut_pulse === 3'b111) nall++;
         else if (dut_pulse !== 3'b000) npart++;
         if (i == 9 && level_o !== 3'b111) begin
            errors++;
            $display("FAIL simul_level: got l=%b, expected 111", level_o);
         end
         if (i == 9) checks++;
         if ({dut_pulse, level_o, glitch_cnt_o} !== {m_pulse, m_stable, m_gcnt}) begin
            errors++;
            $display("FAIL simul_model cyc %0d: got p=%b l=%b g=%h, expected p=%b l=%b g=%h",
                     i, dut_pulse, level_o, glitch_cnt_o, m_pulse, m_stable, m_gcnt);
         end
         checks++;
      end
      if (nall != 1 || npart != 0) begin
         errors++;
         $display("FAIL simul_pulses: got all=%0d partial=%0d, expected 1 0", nall, npart);
      end
      checks++;
      if (glitch_cnt_o !== 16'd4) begin
         errors++;
         $display("FAIL simul_glitch: got g=%h, expected 0004", glitch_cnt_o);
      end
      checks++;
   endtask

   task automatic test_random();
      logic [2:0] cur = 3'b000;
      int hold[3] = '{0, 0, 0};
      logic clr;
      for (int i = 0; i < 400; i++) begin
         for (int c = 0; c < 3; c++) begin
            if (hold[c] == 0) begin
               cur[c]  = 1'($urandom_range(0, 1));
               hold[c] = $urandom_range(1, 8);
            end
            hold[c]--;
         end
         clr = ($urandom_range(0, 31) == 0);
         cycle(cur, clr);
         if ({dut_pulse, level_o, glitch_cnt_o} !== {m_pulse, m_stable, m_gcnt}) begin
            errors++;
            $display("FAIL random_model cyc %0d: got p=%b l=%b g=%h, expected p=%b l=%b g=%h",
                     i, dut_pulse, level_o, glitch_cnt_o, m_pulse, m_stable, m_gcnt);
         end
         checks++;
      end
   endtask

   task automatic test_saturation();
      logic [2:0] tog = 3'b000;
      int extra = 0;
      for (int i = 0; i < 10; i++) cycle(3'b000, 1'b0);
      // Toggling every cycle arms and rejects on all channels repeatedly.
      for (int i = 0; i < 60000 && extra < 20; i++) begin
         tog = ~tog;
         cycle(tog, 1'b0);
         if (m_gcnt == 16'hFFFF) extra++;
         if ({dut_pulse, level_o, glitch_cnt_o} !== {m_pulse, m_stable, m_gcnt}) begin
            errors++;
            $display("FAIL sat_model cyc %0d: got p=%b l=%b g=%h, expected p=%b l=%b g=%h",
                     i, dut_pulse, level_o, glitch_cnt_o, m_pulse, m_stable, m_gcnt);
         end
         checks++;
      end
      if (extra < 20 || glitch_cnt_o !== 16'hFFFF) begin
         errors++;
         $display("FAIL sat_hold: got g=%h after %0d saturated cycles, expected FFFF after 20", glitch_cnt_o, extra);
      end
      checks++;
      // Two clear cycles while toggling: one of them coincides with a glitch.
      for (int i = 0; i < 2; i++) begin
         tog = ~tog;
         cycle(tog, 1'b1);
      end
      if (glitch_cnt_o !== 16'h0000) begin
         errors++;
         $display("FAIL clear_wins: got g=%h, expected 0000", glitch_cnt_o);
      end
      checks++;
      for (int i = 0; i < 10; i++) begin
         cycle(3'b000, 1'b0);
         if ({dut_pulse, level_o, glitch_cnt_o} !== {m_pulse, m_stable, m_gcnt}) begin
            errors++;
            $display("FAIL post_clear_model cyc %0d: got p=%b l=%b g=%h, expected p=%b l=%b g=%h",
                     i, dut_pulse, level_o, glitch_cnt_o, m_pulse, m_stable, m_gcnt);
         end
         checks++;
      end
   endtask

   task automatic test_reset_mid();
      bit reached = 1'b0;
      int npulse = 0;
      int first = -1;
      for (int i = 0; i < 20 && !reached; i++) begin
         cycle(3'b001, 1'b0);
         if (m_run[0] == 2) reached = 1'b1;
      end
      if (!reached) begin
         errors++;
         $display("FAIL reset_mid_arm: got no mid-debounce point within 20 cycles, expected one");
      end
      checks++;
      rst_an_i = 1'b0;
      #1;
      if ({dut_pulse, level_o, glitch_cnt_o} !== 22'd0) begin
         errors++;
         $display("FAIL reset_mid_async: got p=%b l=%b g=%h, expected all zero", dut_pulse, level_o, glitch_cnt_o);
      end
      checks++;
      model_reset();
      start_i = 1'b0; capture_i = 1'b0; rst_capture_i = 1'b1;
      @(negedge clk);
      rst_an_i = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cycle(3'b100, 1'b0);
         if (rst_capture_in_rising_o === 1'b1) begin
            npulse++;
            if (first < 0) first = i;
         end
         if ({dut_pulse, level_o, glitch_cnt_o} !== {m_pulse, m_stable, m_gcnt}) begin
            errors++;
            $display("FAIL reset_release_model cyc %0d: got p=%b l=%b g=%h, expected p=%b l=%b g=%h",
                     i, dut_pulse, level_o, glitch_cnt_o, m_pulse, m_stable, m_gcnt);
         end
         checks++;
      end
      if (npulse != 1 || first != SS + DC - 1) begin
         errors++;
         $display("FAIL reset_release_pulse: got %0d pulses first after edge %0d, expected 1 after edge %0d",
                  npulse, first, SS + DC - 1);
      end
      checks++;
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_clean_rise();
      test_glitch();
      test_fall_rerise();
      test_simultaneous();
      test_random();
      test_saturation();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
